// File: rtl/fft_pkg.sv
// Shared Q-format constants, complex-word type and rounding/saturation helpers
// for the FFT datapath.
package fft_pkg;
    localparam int FRAC_BITS = 8;
    localparam logic signed [15:0] ONE     = 16'sh0100;
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // Intermediate results are carried sign-extended at this width.
    typedef logic signed [63:0] wide_t;

    function automatic logic ovf(input wide_t v, input int w);
        wide_t hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (v > hi) || (v < (-hi - 64'sd1));
    endfunction

    // Round half-up, then arithmetic shift right.
    function automatic wide_t rnd_shr(input wide_t v, input int sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction
endpackage

// File: rtl/fft_bfly_r2_cmul_q88.sv
// Stages S1-S3 of the butterfly: operand/twiddle capture, product register,
// then rounded and saturated W*B, with A delayed alongside.
module cmul_q88
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic                 inv,
    input  logic [WORD_SIZE-1:0] a_re,
    input  logic [WORD_SIZE-1:0] a_im,
    input  logic [WORD_SIZE-1:0] b_re,
    input  logic [WORD_SIZE-1:0] b_im,
    input  logic [WORD_SIZE-1:0] w_re,
    input  logic [WORD_SIZE-1:0] w_im,
    output logic                 out_valid,
    output logic                 out_sat,
    output logic [WORD_SIZE-1:0] a_re_d,
    output logic [WORD_SIZE-1:0] a_im_d,
    output logic [WORD_SIZE-1:0] wb_re,
    output logic [WORD_SIZE-1:0] wb_im
);
    localparam int PW = 2 * WORD_SIZE;
    typedef logic signed [PW-1:0] prod_t;

    function automatic logic [WORD_SIZE-1:0] clamp(input wide_t v);
        if (ovf(v, WORD_SIZE))
            return v[63] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
        return v[WORD_SIZE-1:0];
    endfunction

    logic                 v1, v2, v3;
    logic                 s1, s2, s3;
    logic [WORD_SIZE-1:0] a1_re, a1_im, b1_re, b1_im, w1_re, w1_im;
    logic [WORD_SIZE-1:0] a2_re, a2_im, a3_re, a3_im, wb3_re, wb3_im;
    prod_t                p_rr, p_ii, p_ri, p_ir;

    // Conjugation negates W_im; only the most negative code can overflow.
    wide_t neg_im, sum_re, sum_im;
    assign neg_im = -wide_t'($signed(w_im));
    assign sum_re = rnd_shr(wide_t'(p_rr) - wide_t'(p_ii), FRAC_BITS);
    assign sum_im = rnd_shr(wide_t'(p_ri) + wide_t'(p_ir), FRAC_BITS);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {v1, v2, v3, s1, s2, s3} <= '0;
            {a1_re, a1_im, b1_re, b1_im, w1_re, w1_im} <= '0;
            {a2_re, a2_im, a3_re, a3_im, wb3_re, wb3_im} <= '0;
            {p_rr, p_ii, p_ri, p_ir} <= '0;
        end else if (!stall) begin
            // NOTE: non-blocking assignments so each stage reads the previous stage's pre-edge value.
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                a1_re <= a_re;
                a1_im <= a_im;
                b1_re <= b_re;
                b1_im <= b_im;
                w1_re <= w_re;
                w1_im <= inv ? clamp(neg_im) : w_im;
                s1    <= inv & ovf(neg_im, WORD_SIZE);
            end
            if (v1) begin
                p_rr  <= prod_t'($signed(b1_re)) * prod_t'($signed(w1_re));
                p_ii  <= prod_t'($signed(b1_im)) * prod_t'($signed(w1_im));
                p_ri  <= prod_t'($signed(b1_re)) * prod_t'($signed(w1_im));
                p_ir  <= prod_t'($signed(b1_im)) * prod_t'($signed(w1_re));
                a2_re <= a1_re;
                a2_im <= a1_im;
                s2    <= s1;
            end
            if (v2) begin
                wb3_re <= clamp(sum_re);
                wb3_im <= clamp(sum_im);
                a3_re  <= a2_re;
                a3_im  <= a2_im;
                s3     <= s2 | ovf(sum_re, WORD_SIZE) | ovf(sum_im, WORD_SIZE);
            end
        end
    end

    assign out_valid = v3;
    assign out_sat   = s3;
    assign a_re_d    = a3_re;
    assign a_im_d    = a3_im;
    assign wb_re     = wb3_re;
    assign wb_im     = wb3_im;
endmodule

// File: rtl/fft_bfly_r2.sv
// Radix-2 DIT butterfly X = A + W*B, Y = A - W*B with twiddle select,
// start-up hold, stall and optional output halving.
module fft_bfly_r2
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int SCALE     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_stall,
    input  logic [WORD_SIZE-1:0] i_a_re,
    input  logic [WORD_SIZE-1:0] i_a_im,
    input  logic [WORD_SIZE-1:0] i_b_re,
    input  logic [WORD_SIZE-1:0] i_b_im,
    input  logic [2:0]           i_k,
    input  logic                 i_inv,
    input  logic [WORD_SIZE-1:0] i_tw0_re, i_tw0_im, i_tw1_re, i_tw1_im,
    input  logic [WORD_SIZE-1:0] i_tw2_re, i_tw2_im, i_tw3_re, i_tw3_im,
    input  logic [WORD_SIZE-1:0] i_tw4_re, i_tw4_im, i_tw5_re, i_tw5_im,
    input  logic [WORD_SIZE-1:0] i_tw6_re, i_tw6_im, i_tw7_re, i_tw7_im,
    output logic                 o_valid,
    output logic [WORD_SIZE-1:0] o_x_re,
    output logic [WORD_SIZE-1:0] o_x_im,
    output logic [WORD_SIZE-1:0] o_y_re,
    output logic [WORD_SIZE-1:0] o_y_im,
    output logic                 o_sat
);
    function automatic logic [WORD_SIZE-1:0] clamp(input wide_t v);
        if (ovf(v, WORD_SIZE))
            return v[63] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
        return v[WORD_SIZE-1:0];
    endfunction

    function automatic wide_t scaled(input wide_t v);
        return (SCALE != 0) ? rnd_shr(v, 1) : v;
    endfunction

    // The twiddle ROM is not valid on the first cycle out of reset; hold off two edges.
    logic [1:0] hold_cnt;
    logic       accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                 hold_cnt <= 2'd0;
        else if (hold_cnt != 2'd2) hold_cnt <= hold_cnt + 2'd1;
    end

    assign o_ready = (hold_cnt == 2'd2);
    assign accept  = i_valid & o_ready & ~i_stall;

    logic [WORD_SIZE-1:0] w_re, w_im;

    always_comb begin
        // NOTE: defaults first, so every path assigns w_re/w_im and no latch is inferred.
        w_re = i_tw0_re;
        w_im = i_tw0_im;
        case (i_k)
            3'd1: begin w_re = i_tw1_re; w_im = i_tw1_im; end
            3'd2: begin w_re = i_tw2_re; w_im = i_tw2_im; end
            3'd3: begin w_re = i_tw3_re; w_im = i_tw3_im; end
            3'd4: begin w_re = i_tw4_re; w_im = i_tw4_im; end
            3'd5: begin w_re = i_tw5_re; w_im = i_tw5_im; end
            3'd6: begin w_re = i_tw6_re; w_im = i_tw6_im; end
            3'd7: begin w_re = i_tw7_re; w_im = i_tw7_im; end
            default: ;
        endcase
    end

    logic                 v3, s3;
    logic [WORD_SIZE-1:0] a_re_d, a_im_d, wb_re, wb_im;

    cmul_q88 #(.WORD_SIZE(WORD_SIZE)) u_cmul (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .stall    (i_stall),
        .in_valid (accept),
        .inv      (i_inv),
        .a_re     (i_a_re),
        .a_im     (i_a_im),
        .b_re     (i_b_re),
        .b_im     (i_b_im),
        .w_re     (w_re),
        .w_im     (w_im),
        .out_valid(v3),
        .out_sat  (s3),
        .a_re_d   (a_re_d),
        .a_im_d   (a_im_d),
        .wb_re    (wb_re),
        .wb_im    (wb_im)
    );

    wide_t x_re_w, x_im_w, y_re_w, y_im_w;
    assign x_re_w = scaled(wide_t'($signed(a_re_d)) + wide_t'($signed(wb_re)));
    assign x_im_w = scaled(wide_t'($signed(a_im_d)) + wide_t'($signed(wb_im)));
    assign y_re_w = scaled(wide_t'($signed(a_re_d)) - wide_t'($signed(wb_re)));
    assign y_im_w = scaled(wide_t'($signed(a_im_d)) - wide_t'($signed(wb_im)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
            {o_x_re, o_x_im, o_y_re, o_y_im} <= '0;
        end else if (!i_stall) begin
            o_valid <= v3;
            if (v3) begin
                o_x_re <= clamp(x_re_w);
                o_x_im <= clamp(x_im_w);
                o_y_re <= clamp(y_re_w);
                o_y_im <= clamp(y_im_w);
                o_sat  <= s3 | ovf(x_re_w, WORD_SIZE) | ovf(x_im_w, WORD_SIZE)
                             | ovf(y_re_w, WORD_SIZE) | ovf(y_im_w, WORD_SIZE);
            end
        end
    end
endmodule

// File: tb/tb_fft_bfly_r2.sv
// Scoreboard bench: two butterflies (SCALE=0 and SCALE=1) share stimulus;
// expected results come from a plain-arithmetic complex model.
module tb_fft_bfly_r2;
    import fft_pkg::*;

    localparam int TW_RE[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    localparam int TW_IM[8] = '{0, 98, 181, 237, 256, 237, 181, 98};

    typedef struct packed {int ar; int ai; int br; int bi; logic [2:0] k; bit inv;} vec_t;
    typedef struct packed {int xr; int xi; int yr; int yi; bit sat;} res_t;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_stall = 1'b0, i_inv = 1'b0;
    logic [15:0] i_a_re = '0, i_a_im = '0, i_b_re = '0, i_b_im = '0;
    logic [2:0]  i_k = '0;
    logic        rdy0, rdy1, val0, val1, sat0, sat1;
    logic [15:0] xr0, xi0, yr0, yi0, xr1, xi1, yr1, yi1;
    logic        rom_live;
    cplx_t       rom_word[8];

    res_t q0[$], q1[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, acc_cyc = 0, lat_acc = 0, lat_cyc = -100;
    bit   want_lat = 0, last_stall = 0;
    int   run = 0, max_run = 0;
    bit   have_prev[2];
    logic [65:0] prev[2];

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc        <= cyc + 1;
        last_stall <= i_stall;
    end

    // ROM model: zeros on the first cycle after reset release.
    always @(posedge i_clk or posedge i_rst)
        if (i_rst) rom_live <= 1'b0;
        else       rom_live <= 1'b1;

    always_comb
        for (int i = 0; i < 8; i++) begin
            rom_word[i].re = rom_live ? 16'(TW_RE[i]) : 16'sh0;
            rom_word[i].im = rom_live ? 16'(TW_IM[i]) : 16'sh0;
        end

    fft_bfly_r2 #(.WORD_SIZE(16), .SCALE(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy0), .i_stall(i_stall),
        .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re), .i_b_im(i_b_im), .i_k(i_k), .i_inv(i_inv),
        .i_tw0_re(rom_word[0].re), .i_tw0_im(rom_word[0].im), .i_tw1_re(rom_word[1].re), .i_tw1_im(rom_word[1].im),
        .i_tw2_re(rom_word[2].re), .i_tw2_im(rom_word[2].im), .i_tw3_re(rom_word[3].re), .i_tw3_im(rom_word[3].im),
        .i_tw4_re(rom_word[4].re), .i_tw4_im(rom_word[4].im), .i_tw5_re(rom_word[5].re), .i_tw5_im(rom_word[5].im),
        .i_tw6_re(rom_word[6].re), .i_tw6_im(rom_word[6].im), .i_tw7_re(rom_word[7].re), .i_tw7_im(rom_word[7].im),
        .o_valid(val0), .o_x_re(xr0), .o_x_im(xi0), .o_y_re(yr0), .o_y_im(yi0), .o_sat(sat0));

    fft_bfly_r2 #(.WORD_SIZE(16), .SCALE(1)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy1), .i_stall(i_stall),
        .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re), .i_b_im(i_b_im), .i_k(i_k), .i_inv(i_inv),
        .i_tw0_re(rom_word[0].re), .i_tw0_im(rom_word[0].im), .i_tw1_re(rom_word[1].re), .i_tw1_im(rom_word[1].im),
        .i_tw2_re(rom_word[2].re), .i_tw2_im(rom_word[2].im), .i_tw3_re(rom_word[3].re), .i_tw3_im(rom_word[3].im),
        .i_tw4_re(rom_word[4].re), .i_tw4_im(rom_word[4].im), .i_tw5_re(rom_word[5].re), .i_tw5_im(rom_word[5].im),
        .i_tw6_re(rom_word[6].re), .i_tw6_im(rom_word[6].im), .i_tw7_re(rom_word[7].re), .i_tw7_im(rom_word[7].im),
        .o_valid(val1), .o_x_re(xr1), .o_x_im(xi1), .o_y_re(yr1), .o_y_im(yi1), .o_sat(sat1));

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // floor((v + d/2) / d): round half-up division.
    function automatic longint rdiv(input longint v, input longint d);
        longint n, q;
        n = v + d / 2;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int sat16(input longint v, inout bit s);
        if (v > 32767)  begin s = 1'b1; return 32767;  end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return int'(v);
    endfunction

    function automatic res_t model(input vec_t v, input bit scale);
        res_t   r;
        bit     s;
        longint wr, wi, pr, pi, xr, xi, yr, yi;
        s  = 1'b0;
        wr = TW_RE[v.k];
        wi = TW_IM[v.k];
        if (v.inv) wi = sat16(-wi, s);
        pr = sat16(rdiv(longint'(v.br) * wr - longint'(v.bi) * wi, 256), s);
        pi = sat16(rdiv(longint'(v.br) * wi + longint'(v.bi) * wr, 256), s);
        xr = v.ar + pr;  xi = v.ai + pi;
        yr = v.ar - pr;  yi = v.ai - pi;
        if (scale) begin
            xr = rdiv(xr, 2); xi = rdiv(xi, 2); yr = rdiv(yr, 2); yi = rdiv(yi, 2);
        end
        r.xr = sat16(xr, s); r.xi = sat16(xi, s);
        r.yr = sat16(yr, s); r.yi = sat16(yi, s);
        r.sat = s;
        return r;
    endfunction

    // ---------------- monitor ----------------
    task automatic mon(input int d, input logic v, input logic s,
                       input logic [15:0] xr, input logic [15:0] xi,
                       input logic [15:0] yr, input logic [15:0] yi);
        logic [65:0] snap;
        res_t        e;
        snap = {v, s, xr, xi, yr, yi};
        if (i_rst) begin
            have_prev[d] = 1'b0;
            return;
        end
        if (last_stall && have_prev[d]) begin
            check($sformatf("freeze_data_dut%0d", d), longint'(snap[63:0]), longint'(prev[d][63:0]));
            check($sformatf("freeze_flags_dut%0d", d), longint'(snap[65:64]), longint'(prev[d][65:64]));
        end else if (!last_stall && v) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                check($sformatf("unexpected_output_dut%0d", d), 1, 0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("x_re_dut%0d", d), longint'($signed(xr)), e.xr);
                check($sformatf("x_im_dut%0d", d), longint'($signed(xi)), e.xi);
                check($sformatf("y_re_dut%0d", d), longint'($signed(yr)), e.yr);
                check($sformatf("y_im_dut%0d", d), longint'($signed(yi)), e.yi);
                check($sformatf("sat_dut%0d", d), longint'(s), longint'(e.sat));
            end
        end
        if (d == 0 && !last_stall) begin
            if (v) begin
                run = run + 1;
                if (run > max_run) max_run = run;
                if (want_lat) begin lat_cyc = cyc; want_lat = 1'b0; end
            end else begin
                run = 0;
            end
        end
        prev[d]      = snap;
        have_prev[d] = 1'b1;
    endtask

    always @(negedge i_clk) begin
        mon(0, val0, sat0, xr0, xi0, yr0, yi0);
        mon(1, val1, sat1, xr1, xi1, yr1, yi1);
    end

    // ---------------- driver ----------------
    function automatic int rnd16();
        logic [15:0] r;
        case ($urandom_range(0, 7))
            0:       r = 16'h7FFF;
            1:       r = 16'h8000;
            default: r = 16'($urandom);
        endcase
        return int'($signed(r));
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.ar = rnd16(); v.ai = rnd16(); v.br = rnd16(); v.bi = rnd16();
        v.k = 3'($urandom_range(0, 7));
        v.inv = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic vec_t mk(input int ar, input int ai, input int br, input int bi,
                                input int k, input bit inv);
        vec_t v;
        v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.k = 3'(k); v.inv = inv;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        i_a_re = 16'(v.ar); i_a_im = 16'(v.ai);
        i_b_re = 16'(v.br); i_b_im = 16'(v.bi);
        i_k = v.k; i_inv = v.inv;
    endtask

    task automatic push(input vec_t v);
        q0.push_back(model(v, 1'b0));
        q1.push_back(model(v, 1'b1));
        acc_cyc = cyc + 1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input vec_t v);
        bit done;
        done = 1'b0;
        drive(v);
        i_valid = 1'b1;
        i_stall = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (rdy0) begin
                push(v);
                done = 1'b1;
                @(negedge i_clk);
                break;
            end
            @(negedge i_clk);
        end
        if (!done) check("ready_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic stall_cycles(input int n, input vec_t v);
        drive(v);
        i_valid = 1'b1;
        i_stall = 1'b1;
        repeat (n) @(negedge i_clk);
        i_stall = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge i_clk);
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    task automatic check_reset_state();
        check("rst_ready0", rdy0, 0);  check("rst_ready1", rdy1, 0);
        check("rst_valid0", val0, 0);  check("rst_valid1", val1, 0);
        check("rst_sat0", sat0, 0);    check("rst_sat1", sat1, 0);
        check("rst_out0", longint'({xr0, xi0, yr0, yi0}), 0);
        check("rst_out1", longint'({xr1, xi1, yr1, yi1}), 0);
    endtask

    // Called at a negedge with i_rst high; releases reset with i_valid held.
    task automatic startup(input vec_t v);
        drive(v);
        i_valid = 1'b1;
        i_rst   = 1'b0;
        @(negedge i_clk);
        check("ready_after_edge1_dut0", rdy0, 0);
        check("ready_after_edge1_dut1", rdy1, 0);
        @(negedge i_clk);
        check("ready_after_edge2_dut0", rdy0, 1);
        check("ready_after_edge2_dut1", rdy1, 1);
        push(v);
        lat_acc  = acc_cyc;
        want_lat = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (2) @(negedge i_clk);
        check_reset_state();

        startup(mk(256, 0, 256, 0, 0, 0));
        drain();
        // Four register stages: acceptance edge, then o_valid set three edges later.
        check("first_valid_latency", lat_cyc - lat_acc, 3);

        issue(mk(256, 0, 256, 0, 4, 0));
        issue(mk(256, 0, 256, 0, 4, 1));
        issue(mk(32512, 0, 32512, 0, 0, 0));
        issue(mk(0, 0, 0, -32768, 4, 0));
        drain();

        @(negedge i_clk);
        run = 0;
        max_run = 0;
        repeat (8) issue(mk(0, 0, 256, 0, 2, 0));
        drain();
        repeat (2) @(negedge i_clk);
        check("burst_consecutive_valids", max_run, 8);

        repeat (3) issue(rnd_vec());
        stall_cycles(3, rnd_vec());
        repeat (3) issue(rnd_vec());
        drain();

        for (int n = 0; n < 40; n++) begin
            issue(rnd_vec());
            if ($urandom_range(0, 5) == 0) stall_cycles(int'($urandom_range(1, 2)), rnd_vec());
            i_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        drain();

        repeat (4) issue(rnd_vec());
        check("pre_reset_valid", val0, 1);
        i_rst = 1'b1;
        #1;
        check_reset_state();
        q0.delete();
        q1.delete();
        @(negedge i_clk);
        startup(rnd_vec());
        repeat (3) issue(rnd_vec());
        drain();

        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
